// File: rtl/rr_mem_arbiter8.sv
// Round-robin arbiter sharing one memory port among eight requesters.
// Holds the winner for a whole transaction, with optional timeout abort.
module rr_mem_arbiter8 #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_read,
  input  logic [7:0] req_write,
  input  logic       mem_resp,
  output logic [2:0] sel,
  output logic [7:0] grant,
  output logic       mem_read,
  output logic       mem_write,
  output logic [7:0] resp,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_t;

  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nx;
  logic [2:0] ptr;
  logic [2:0] win;
  logic [2:0] idx;
  logic       found;
  logic       op_rd;
  logic [7:0] cnt;
  logic [7:0] pending;
  logic       tmo;

  assign pending = req_read | req_write;
  assign tmo     = (TIMEOUT != 0) && (cnt == TLIM);

  // First pending requester at or above ptr, wrapping 7 -> 0.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && pending[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Next state and strobes; resp/err are suppressed while reset is asserted.
  always_comb begin
    state_nx  = state;
    grant     = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    resp      = '0;
    err       = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) state_nx = BUSY;
      end
      BUSY: begin
        grant     = 8'b1 << sel;
        mem_read  = op_rd;
        mem_write = !op_rd;
        if (mem_resp) begin
          resp     = rst ? 8'h00 : (8'b1 << sel);
          state_nx = RELEASE;
        end else if (tmo) begin
          err      = !rst;
          state_nx = RELEASE;
        end
      end
      RELEASE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Winner latch, timeout counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      sel   <= '0;
      op_rd <= 1'b0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            sel   <= win;
            op_rd <= req_read[win];
            cnt   <= '0;
          end
        end
        BUSY: begin
          if (!mem_resp) cnt <= cnt + 8'd1;
        end
        RELEASE: begin
          ptr <= sel + 3'd1;
        end
        default: begin
          ptr <= ptr;
        end
      endcase
    end
  end

endmodule
